seq_scan_ctrl: RTL and testbench
================================

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request to scan one word; sampled only in IDLE.
REQ-004 SHALL have port: data_in  input  16  word to scan; bit index 0 = data_in[15] (MSB first).
REQ-005 SHALL have port: len  input  5  number of bits to scan; 0 = empty scan; values above 16 clamp to 16.
REQ-006 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-007 SHALL have port: done  output  1  one-cycle pulse when a scan completes.
REQ-008 SHALL have port: bit_out  output  1  serial bit currently presented to the detector.
REQ-009 SHALL have port: match_count  output  5  number of matches in the last or current scan.
REQ-010 SHALL have port: match_found  output  1  high once at least one match has occurred in the scan.
REQ-011 SHALL have port: first_match_idx  output  4  bit index completing the first match; 0 when none.

Function
REQ-012 SHALL implement states IDLE, LOAD, SHIFT, FLUSH, DONE.
REQ-013 IDLE, start=1 SHALL: go to LOAD; capture data_in into a shift register; capture clamped len into a bit counter; clear match_count, match_found and first_match_idx.
REQ-014 LOAD SHALL hold the detector in its reset state for one cycle, then go to SHIFT, or to DONE when the captured len is 0.
REQ-015 SHIFT SHALL present one bit per cycle on bit_out, index 0 first, for exactly len cycles, then go to FLUSH.
REQ-016 The detector SHALL assert its registered output the cycle after it receives the final bit of 1111 or 1101; overlapping matches count.
REQ-017 A detector output of 1 during SHIFT (index ≥1) or FLUSH SHALL increment match_count; the matched index is the previous shift index.
REQ-018 On the first increment of a scan, first_match_idx SHALL load the matched index and match_found SHALL set.
REQ-019 FLUSH SHALL last one cycle, then go to DONE; DONE SHALL pulse done for one cycle, then go to IDLE.
REQ-020 Latency: done SHALL assert exactly clamped_len+3 cycles after start is sampled, or 2 cycles when len=0.
REQ-021 start while busy SHALL be ignored with no effect.
REQ-022 Results SHALL hold stable in IDLE until the next accepted start.
REQ-023 match_count SHALL NOT overflow, since the maximum is 13 for 16 bits.
REQ-024 Detector state SHALL NOT carry across scans; a pattern spanning two scans is not a match.
REQ-025 bit_out SHALL be 0 outside SHIFT.

Reset
REQ-026 reset=1 at any clock edge, including mid-scan, SHALL force IDLE and reset the detector.
REQ-027 Under reset, busy, done, bit_out, match_count, match_found and first_match_idx SHALL all be 0.
REQ-028 Reset SHALL take priority over start.

Structure
REQ-029 A shared package SHALL hold: the state encoding (IDLE=0, LOAD=1, SHIFT=2, FLUSH=3, DONE=4, 3 bits), WORD_W=16, MAX_LEN=16, and the 1111/1101 pattern constants.
REQ-030 The 1111/1101 overlapping detector SHALL be a separate sub-module, seq_detector, with ports clock, reset, w, z.
REQ-031 seq_scan_ctrl SHALL drive seq_detector reset with (reset OR state==LOAD).

Verification
REQ-032 start, data_in=16'hF000, len=16 -> match_count=1, first_match_idx=3, match_found=1, done 19 cycles after start.
REQ-033 data_in=16'hFFFF, len=16 -> match_count=13, first_match_idx=3.
REQ-034 data_in=16'hD000, len=4 -> match_count=1, first_match_idx=3; the same word with len=3 -> match_count=0, match_found=0.
REQ-035 Scan 16'hC000 len=2, then scan 16'h4000 len=2 -> second scan match_count=0 (no cross-scan match).
REQ-036 len=0 -> done 2 cycles after start, count 0; len=20 with 16'hFFFF -> behaves as len=16 (count 13).
REQ-037 reset pulsed during SHIFT of 16'hFFFF -> next cycle IDLE with all outputs 0; a start during busy is ignored and the scan result is unchanged.

Source files
------------

// File: rtl/seq_scan_ctrl_pkg.sv
// Shared definitions for the serial pattern scanner: state encoding, widths,
// detector patterns and the length clamp.
package seq_scan_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      FLUSH = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int WORD_W  = 16;
   localparam int MAX_LEN = 16;
   localparam int LEN_W   = 5;
   localparam int IDX_W   = 4;

   localparam logic [3:0] PAT_ALL_ONES = 4'b1111;
   localparam logic [3:0] PAT_GAP      = 4'b1101;

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
      return (l > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : l;
   endfunction

endpackage

// File: rtl/seq_scan_ctrl_detector.sv
// Overlapping 1111 / 1101 detector; z is registered and rises the cycle after
// the final bit of either pattern arrives on w.
module seq_detector
   import seq_scan_ctrl_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic w,
   output logic z
);

   logic [2:0] hist;
   logic [3:0] window;

   // Zeroed history can never fake a match: both patterns begin with 1.
   assign window = {hist, w};

   always_ff @(posedge clock) begin
      if (reset) begin
         hist <= '0;
         z    <= 1'b0;
      end else begin
         hist <= window[2:0];
         z    <= (window == PAT_ALL_ONES) || (window == PAT_GAP);
      end
   end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Scans up to 16 bits MSB-first through the pattern detector, counting matches
// and recording the bit index that completed the first one.
module seq_scan_ctrl
   import seq_scan_ctrl_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [WORD_W-1:0] data_in,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic              bit_out,
   output logic [LEN_W-1:0]  match_count,
   output logic              match_found,
   output logic [IDX_W-1:0]  first_match_idx
);

   state_t            state;
   logic [WORD_W-1:0] shreg;
   logic [LEN_W-1:0]  remain;
   logic [IDX_W-1:0]  pos;
   logic              det_reset;
   logic              det_z;
   logic              hit;

   assign det_reset = reset | (state == LOAD);

   // pos is the index on bit_out, so a detector hit refers to pos-1; pos also
   // advances into FLUSH (wrapping 15->0), keeping pos-1 correct there too.
   assign hit = det_z && (((state == SHIFT) && (pos != '0)) || (state == FLUSH));

   seq_detector u_det (
      .clock (clock),
      .reset (det_reset),
      .w     (bit_out),
      .z     (det_z)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         shreg           <= '0;
         remain          <= '0;
         pos             <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         bit_out         <= 1'b0;
         match_count     <= '0;
         match_found     <= 1'b0;
         first_match_idx <= '0;
      end else begin
         if (hit) begin
            match_count <= match_count + LEN_W'(1);
            if (!match_found) begin
               match_found     <= 1'b1;
               first_match_idx <= pos - IDX_W'(1);
            end
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state           <= LOAD;
                  busy            <= 1'b1;
                  shreg           <= data_in;
                  remain          <= clamp_len(len);
                  pos             <= '0;
                  match_count     <= '0;
                  match_found     <= 1'b0;
                  first_match_idx <= '0;
               end
            end

            LOAD: begin
               if (remain == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state   <= SHIFT;
                  bit_out <= shreg[WORD_W-1];
                  shreg   <= {shreg[WORD_W-2:0], 1'b0};
                  remain  <= remain - LEN_W'(1);
               end
            end

            SHIFT: begin
               pos <= pos + IDX_W'(1);
               if (remain == '0) begin
                  state   <= FLUSH;
                  bit_out <= 1'b0;
               end else begin
                  bit_out <= shreg[WORD_W-1];
                  shreg   <= {shreg[WORD_W-2:0], 1'b0};
                  remain  <= remain - LEN_W'(1);
               end
            end

            FLUSH: begin
               state <= DONE;
               done  <= 1'b1;
            end

            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end

            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
               bit_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed table of scans plus hand-written reset and busy-start sequences.
module tb_seq_scan_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] data_in;
   logic [4:0]  len;
   logic        busy;
   logic        done;
   logic        bit_out;
   logic [4:0]  match_count;
   logic        match_found;
   logic [3:0]  first_match_idx;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   seq_scan_ctrl dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .data_in         (data_in),
      .len             (len),
      .busy            (busy),
      .done            (done),
      .bit_out         (bit_out),
      .match_count     (match_count),
      .match_found     (match_found),
      .first_match_idx (first_match_idx)
   );

   typedef struct {
      logic [15:0] data;
      logic [4:0]  len;
      int          count;
      int          found;
      int          first;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Cycle 0 is the cycle start is sampled in; returns the cycle done is seen
   // (0 if it never comes) and the number of wrong bit_out samples.
   task automatic do_scan(input logic [15:0] d, input logic [4:0] l, input int inject_at,
                          output int lat, output int bit_err);
      int cl;
      int exp_bit;
      cl = (l > 5'd16) ? 16 : int'(l);
      @(negedge clock);
      data_in = d;
      len     = l;
      start   = 1'b1;
      lat     = 0;
      bit_err = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clock);
         start = 1'b0;
         if (c == inject_at) begin
            start   = 1'b1;
            data_in = 16'hFFFF;
            len     = 5'd16;
         end
         exp_bit = (c >= 2 && c <= cl + 1) ? int'(d[15 - (c - 2)]) : 0;
         if (int'(bit_out) != exp_bit) bit_err++;
         if (done) begin
            lat = c;
            break;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      int lat;
      int berr;
      int held;

      vecs[0]  = '{16'hF000, 5'd16, 1,  1, 3,  19};
      vecs[1]  = '{16'hFFFF, 5'd16, 13, 1, 3,  19};
      vecs[2]  = '{16'hD000, 5'd4,  1,  1, 3,  7};
      vecs[3]  = '{16'hD000, 5'd3,  0,  0, 0,  6};
      vecs[4]  = '{16'hC000, 5'd2,  0,  0, 0,  5};
      vecs[5]  = '{16'h4000, 5'd2,  0,  0, 0,  5};
      vecs[6]  = '{16'hFFFF, 5'd0,  0,  0, 0,  2};
      vecs[7]  = '{16'hFFFF, 5'd20, 13, 1, 3,  19};
      vecs[8]  = '{16'hDF00, 5'd16, 3,  1, 3,  19};
      vecs[9]  = '{16'h1B00, 5'd10, 1,  1, 6,  13};
      vecs[10] = '{16'hFFFF, 5'd1,  0,  0, 0,  4};
      vecs[11] = '{16'h000D, 5'd16, 1,  1, 15, 19};

      reset   = 1'b1;
      start   = 1'b0;
      data_in = '0;
      len     = '0;
      repeat (3) @(negedge clock);
      check("reset_outputs",
            int'({busy, done, bit_out, match_count, match_found, first_match_idx}), 0);
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 12; i++) begin
         do_scan(vecs[i].data, vecs[i].len, 0, lat, berr);
         check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("v%0d_bits", i), berr, 0);
         check($sformatf("v%0d_count", i), int'(match_count), vecs[i].count);
         check($sformatf("v%0d_found", i), int'(match_found), vecs[i].found);
         check($sformatf("v%0d_first", i), int'(first_match_idx), vecs[i].first);
         held = int'(match_count);
         @(negedge clock);
         check($sformatf("v%0d_done_pulse", i), int'({done, busy}), 0);
         @(negedge clock);
         check($sformatf("v%0d_hold", i), int'(match_count), held);
      end

      // Reset in the middle of a scan that has already counted matches.
      @(negedge clock);
      data_in = 16'hFFFF;
      len     = 5'd16;
      start   = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (8) @(negedge clock);
      check("mid_scan_busy", int'(busy), 1);
      check("mid_scan_counting", int'(match_count != 0), 1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("mid_reset_outputs",
            int'({busy, done, bit_out, match_count, match_found, first_match_idx}), 0);
      @(negedge clock);
      check("mid_reset_idle", int'(busy), 0);

      // Reset and start together: reset wins, no scan begins.
      reset = 1'b1;
      start = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      start = 1'b0;
      check("reset_over_start", int'(busy), 0);
      @(negedge clock);
      check("reset_over_start_next", int'(busy), 0);

      // A start raised while busy must not disturb the running scan.
      do_scan(16'hF000, 5'd16, 5, lat, berr);
      check("busy_start_latency", lat, 19);
      check("busy_start_bits", berr, 0);
      check("busy_start_count", int'(match_count), 1);
      check("busy_start_first", int'(first_match_idx), 3);
      @(negedge clock);
      check("busy_start_no_rescan", int'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
